// File: rtl/hazard_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard controller:
// forwarding-select encodings, the scoreboard entry and MDU latency defaults.
package hazard_ctrl_pkg;

   localparam logic [1:0] FWD_RF  = 2'd0;
   localparam logic [1:0] FWD_MEM = 2'd1;
   localparam logic [1:0] FWD_WB  = 2'd2;

   localparam int MULT_CYCLES_DEF = 5;
   localparam int DIV_CYCLES_DEF  = 10;

   typedef struct packed {
      logic       valid;
      logic [4:0] addr;
      logic       is_load;
   } sb_entry_t;

   // Invalid entries are kept all-zero so they can never alias a real source.
   function automatic logic src_match(input sb_entry_t e, input logic [4:0] src,
                                      input logic use_src);
      return e.valid && (e.addr == src) && (src != 5'd0) && use_src;
   endfunction

   function automatic logic entry_ok(input sb_entry_t e);
      return e.valid ? (e.addr != 5'd0) : (e == '0);
   endfunction

endpackage

// File: rtl/hazard_ctrl_mdu_busy_cnt.sv
// Multi-cycle mult/div occupancy counter: loads the op latency on start,
// counts down to zero, and flags busy from the registered count.
module mdu_busy_cnt
   import hazard_ctrl_pkg::*;
#(
   parameter int MULT_CYCLES = MULT_CYCLES_DEF,
   parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
   input  logic clk,
   input  logic reset,
   input  logic i_start,
   input  logic i_is_div,
   output logic o_busy
);

   localparam logic [3:0] MULT_LD = 4'(MULT_CYCLES);
   localparam logic [3:0] DIV_LD  = 4'(DIV_CYCLES);

   logic [3:0] r_cnt;
   logic [3:0] w_cnt_nxt;
   logic       r_busy;

   // A start while already busy simply reloads; legal code never does that.
   always_comb begin
      w_cnt_nxt = r_cnt;
      if (i_start) begin
         w_cnt_nxt = i_is_div ? DIV_LD : MULT_LD;
      end else if (r_cnt != 4'd0) begin
         w_cnt_nxt = r_cnt - 4'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_cnt  <= 4'd0;
         r_busy <= 1'b0;
      end else begin
         r_cnt  <= w_cnt_nxt;
         r_busy <= (w_cnt_nxt != 4'd0);
      end
   end

   assign o_busy = r_busy;

endmodule

// File: rtl/hazard_ctrl.sv
// Hazard controller for the 5-stage core: load-use/MDU stalls, branch flush,
// E-stage forwarding selects. Define HAZARD_PERF_EN to add stall/flush counters.
module hazard_ctrl
   import hazard_ctrl_pkg::*;
#(
   parameter int MULT_CYCLES = MULT_CYCLES_DEF,
   parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       id_valid,
   input  logic [4:0] id_rs,
   input  logic [4:0] id_rt,
   input  logic       id_use_rs,
   input  logic       id_use_rt,
   input  logic [4:0] id_write_addr,
   input  logic       id_reg_write,
   input  logic       id_is_load,
   input  logic       id_is_mdu,
   input  logic       ex_mdu_start,
   input  logic       ex_mdu_is_div,
   input  logic       ex_branch_taken,
   output logic       stall_f,
   output logic       stall_d,
   output logic       flush_d,
   output logic       flush_e,
   output logic [1:0] fwd_a_sel,
   output logic [1:0] fwd_b_sel,
   output logic       mdu_busy
`ifdef HAZARD_PERF_EN
   ,
   output logic [31:0] perf_stall_cnt,
   output logic [31:0] perf_flush_cnt
`endif
);

   sb_entry_t  r_sb_e, r_sb_m, r_sb_w;
   sb_entry_t  w_d_entry;
   logic       w_a_match_e, w_a_match_m, w_b_match_e, w_b_match_m;
   logic       w_lu, w_ms, w_hold, w_flush_e;
   logic       w_mdu_busy;
   logic [1:0] w_fwd_a_nxt, w_fwd_b_nxt;
   logic [1:0] r_fwd_a, r_fwd_b;

   mdu_busy_cnt #(
      .MULT_CYCLES (MULT_CYCLES),
      .DIV_CYCLES  (DIV_CYCLES)
   ) u_mdu_busy_cnt (
      .clk      (clk),
      .reset    (reset),
      .i_start  (ex_mdu_start),
      .i_is_div (ex_mdu_is_div),
      .o_busy   (w_mdu_busy)
   );

   always_comb begin
      w_d_entry = '0;
      if (id_valid && id_reg_write && (id_write_addr != 5'd0)) begin
         w_d_entry.valid   = 1'b1;
         w_d_entry.addr    = id_write_addr;
         w_d_entry.is_load = id_is_load;
      end
   end

   assign w_a_match_e = src_match(r_sb_e, id_rs, id_valid & id_use_rs);
   assign w_b_match_e = src_match(r_sb_e, id_rt, id_valid & id_use_rt);
   assign w_a_match_m = src_match(r_sb_m, id_rs, id_valid & id_use_rs);
   assign w_b_match_m = src_match(r_sb_m, id_rt, id_valid & id_use_rt);

   assign w_lu      = id_valid & r_sb_e.is_load & (w_a_match_e | w_b_match_e);
   assign w_ms      = id_valid & id_is_mdu & (w_mdu_busy | ex_mdu_start);
   // A taken branch discards D anyway, so it wins over any stall.
   assign w_hold    = (w_lu | w_ms) & ~ex_branch_taken;
   assign w_flush_e = w_lu | w_ms | ex_branch_taken;

   // The instruction now in E will be in M (mem_data) when D reaches E;
   // the one in M will be in W. The RF is write-before-read, so W needs nothing.
   always_comb begin
      w_fwd_a_nxt = FWD_RF;
      w_fwd_b_nxt = FWD_RF;
      if (w_a_match_e && !r_sb_e.is_load) w_fwd_a_nxt = FWD_MEM;
      else if (w_a_match_m)               w_fwd_a_nxt = FWD_WB;
      if (w_b_match_e && !r_sb_e.is_load) w_fwd_b_nxt = FWD_MEM;
      else if (w_b_match_m)               w_fwd_b_nxt = FWD_WB;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_sb_e  <= '0;
         r_sb_m  <= '0;
         r_sb_w  <= '0;
         r_fwd_a <= FWD_RF;
         r_fwd_b <= FWD_RF;
      end else begin
         r_sb_w  <= r_sb_m;
         r_sb_m  <= r_sb_e;
         r_sb_e  <= w_flush_e ? '0 : w_d_entry;
         r_fwd_a <= w_flush_e ? FWD_RF : w_fwd_a_nxt;
         r_fwd_b <= w_flush_e ? FWD_RF : w_fwd_b_nxt;
      end
   end

   assert property (@(posedge clk) disable iff (reset)
      entry_ok(r_sb_e) && entry_ok(r_sb_m) && entry_ok(r_sb_w));

   assign stall_f   = w_hold;
   assign stall_d   = w_hold;
   assign flush_d   = ex_branch_taken;
   assign flush_e   = w_flush_e;
   assign fwd_a_sel = r_fwd_a;
   assign fwd_b_sel = r_fwd_b;
   assign mdu_busy  = w_mdu_busy;

`ifdef HAZARD_PERF_EN
   logic [31:0] r_perf_stall, r_perf_flush;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_perf_stall <= 32'd0;
         r_perf_flush <= 32'd0;
      end else begin
         if (w_hold)          r_perf_stall <= r_perf_stall + 32'd1;
         if (ex_branch_taken) r_perf_flush <= r_perf_flush + 32'd1;
      end
   end

   assign perf_stall_cnt = r_perf_stall;
   assign perf_flush_cnt = r_perf_flush;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: a vector table run through an expected-value queue,
// plus hand sequences for MDU latency, mid-stall reset and idle-D rows.
module tb_hazard_ctrl;

   logic       clk = 1'b0;
   logic       reset;
   logic       id_valid, id_use_rs, id_use_rt, id_reg_write, id_is_load, id_is_mdu;
   logic [4:0] id_rs, id_rt, id_write_addr;
   logic       ex_mdu_start, ex_mdu_is_div, ex_branch_taken;
   logic       stall_f, stall_d, flush_d, flush_e, mdu_busy;
   logic [1:0] fwd_a_sel, fwd_b_sel;
`ifdef HAZARD_PERF_EN
   logic [31:0] perf_stall_cnt, perf_flush_cnt;
`endif

   int checks = 0;
   int errors = 0;

   logic [8:0] exp_q[$];
   string      name_q[$];

   always #5 clk = ~clk;

   hazard_ctrl dut (
      .clk             (clk),
      .reset           (reset),
      .id_valid        (id_valid),
      .id_rs           (id_rs),
      .id_rt           (id_rt),
      .id_use_rs       (id_use_rs),
      .id_use_rt       (id_use_rt),
      .id_write_addr   (id_write_addr),
      .id_reg_write    (id_reg_write),
      .id_is_load      (id_is_load),
      .id_is_mdu       (id_is_mdu),
      .ex_mdu_start    (ex_mdu_start),
      .ex_mdu_is_div   (ex_mdu_is_div),
      .ex_branch_taken (ex_branch_taken),
      .stall_f         (stall_f),
      .stall_d         (stall_d),
      .flush_d         (flush_d),
      .flush_e         (flush_e),
      .fwd_a_sel       (fwd_a_sel),
      .fwd_b_sel       (fwd_b_sel),
      .mdu_busy        (mdu_busy)
`ifdef HAZARD_PERF_EN
      ,
      .perf_stall_cnt  (perf_stall_cnt),
      .perf_flush_cnt  (perf_flush_cnt)
`endif
   );

   typedef struct {
      logic       rst;
      logic       valid;
      logic [4:0] rs;
      logic [4:0] rt;
      logic       urs;
      logic       urt;
      logic [4:0] wa;
      logic       rw;
      logic       ld;
      logic       mdu;
      logic       ms;
      logic       md;
      logic       br;
      logic [8:0] exp;
   } vec_t;

   // exp packs {stall_f, stall_d, flush_d, flush_e, fwd_a, fwd_b, mdu_busy}
   function automatic logic [8:0] e(input logic sf, input logic sd, input logic fd,
                                    input logic fe, input logic [1:0] fa,
                                    input logic [1:0] fb, input logic busy);
      return {sf, sd, fd, fe, fa, fb, busy};
   endfunction

   function automatic vec_t v(input logic valid, input logic [4:0] rs, input logic [4:0] rt,
                              input logic urs, input logic urt, input logic [4:0] wa,
                              input logic rw, input logic ld, input logic mdu,
                              input logic ms, input logic md, input logic br,
                              input logic [8:0] exp);
      vec_t t;
      t.rst = 1'b0; t.valid = valid; t.rs = rs; t.rt = rt; t.urs = urs; t.urt = urt;
      t.wa = wa; t.rw = rw; t.ld = ld; t.mdu = mdu; t.ms = ms; t.md = md; t.br = br;
      t.exp = exp;
      return t;
   endfunction

   vec_t  tbl[$];
   string tbl_nm[$];

   task automatic add(input vec_t t, input string nm);
      tbl.push_back(t);
      tbl_nm.push_back(nm);
   endtask

   task automatic apply(input vec_t t, input string nm);
      logic [8:0] act;
      logic [8:0] exp;
      string      n;
      @(posedge clk);
      #1;
      reset           = t.rst;
      id_valid        = t.valid;
      id_rs           = t.rs;
      id_rt           = t.rt;
      id_use_rs       = t.urs;
      id_use_rt       = t.urt;
      id_write_addr   = t.wa;
      id_reg_write    = t.rw;
      id_is_load      = t.ld;
      id_is_mdu       = t.mdu;
      ex_mdu_start    = t.ms;
      ex_mdu_is_div   = t.md;
      ex_branch_taken = t.br;
      exp_q.push_back(t.exp);
      name_q.push_back(nm);
      @(negedge clk);
      act = {stall_f, stall_d, flush_d, flush_e, fwd_a_sel, fwd_b_sel, mdu_busy};
      exp = exp_q.pop_front();
      n   = name_q.pop_front();
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got sf,sd,fd,fe,fa,fb,busy=%b want %b", n, act, exp);
      end
   endtask

   localparam logic [8:0] Z = 9'd0;

   initial begin
      vec_t t;
      logic [8:0] stall_busy;
      stall_busy = e(1, 1, 0, 1, 2'd0, 2'd0, 1);

      reset = 1'b1;
      id_valid = 0; id_rs = 0; id_rt = 0; id_use_rs = 0; id_use_rt = 0;
      id_write_addr = 0; id_reg_write = 0; id_is_load = 0; id_is_mdu = 0;
      ex_mdu_start = 0; ex_mdu_is_div = 0; ex_branch_taken = 0;
      repeat (2) @(posedge clk);

      //           valid rs   rt  urs urt wa  rw ld mdu ms md br exp
      add(v(0, 0,  0,  0, 0, 0,  0, 0, 0, 0, 0, 0, Z), "reset_state");
      add(v(1, 1,  2,  1, 1, 3,  1, 0, 0, 0, 0, 0, Z), "alu_add3");
      add(v(1, 3,  5,  1, 1, 4,  1, 0, 0, 0, 0, 0, Z), "alu_sub_dep_no_stall");
      add(v(1, 3,  7,  1, 1, 6,  1, 0, 0, 0, 0, 0, e(0,0,0,0,2'd1,2'd0,0)), "alu_sub_fwd_mem");
      add(v(0, 0,  0,  0, 0, 0,  0, 0, 0, 0, 0, 0, e(0,0,0,0,2'd2,2'd0,0)), "alu_slot2_fwd_wb");
      add(v(1, 1,  0,  1, 0, 8,  1, 1, 0, 0, 0, 0, Z), "lw8");
      add(v(1, 8,  8,  1, 1, 9,  1, 0, 0, 0, 0, 0, e(1,1,0,1,2'd0,2'd0,0)), "load_use_stall");
      add(v(1, 8,  8,  1, 1, 9,  1, 0, 0, 0, 0, 0, Z), "load_use_one_cycle");
      add(v(0, 0,  0,  0, 0, 0,  0, 0, 0, 0, 0, 0, e(0,0,0,0,2'd2,2'd2,0)), "load_use_fwd_wb");
      add(v(1, 1,  2,  1, 1, 0,  1, 0, 0, 0, 0, 0, Z), "r0_write");
      add(v(1, 0,  0,  1, 1, 10, 1, 0, 0, 0, 0, 0, Z), "r0_use");
      add(v(0, 0,  0,  0, 0, 0,  0, 0, 0, 0, 0, 0, Z), "r0_fwd_zero");
      add(v(1, 1,  0,  1, 0, 0,  1, 1, 0, 0, 0, 0, Z), "r0_load");
      add(v(1, 0,  0,  1, 1, 11, 1, 0, 0, 0, 0, 0, Z), "r0_load_use_no_stall");
      add(v(0, 0,  0,  0, 0, 0,  0, 0, 0, 0, 0, 0, Z), "r0_load_fwd_zero");
      add(v(1, 1,  0,  1, 0, 12, 1, 1, 0, 0, 0, 0, Z), "lw12");
      add(v(1, 12, 12, 1, 1, 13, 1, 0, 0, 0, 0, 1, e(0,0,1,1,2'd0,2'd0,0)), "branch_over_lu");
      add(v(1, 12, 12, 1, 1, 13, 1, 0, 0, 0, 0, 0, Z), "branch_no_residual");
      add(v(0, 0,  0,  0, 0, 0,  0, 0, 0, 0, 0, 0, e(0,0,0,0,2'd2,2'd2,0)), "branch_after_fwd");

      for (int i = 0; i < tbl.size(); i++) apply(tbl[i], tbl_nm[i]);

      // div issues in E with mflo in D: 11 stall cycles, issue as busy drops
      apply(v(1, 0, 0, 0, 0, 14, 1, 0, 1, 1, 1, 0, e(1,1,0,1,2'd0,2'd0,0)), "div_start_stall");
      for (int i = 0; i < 10; i++)
         apply(v(1, 0, 0, 0, 0, 14, 1, 0, 1, 0, 0, 0, stall_busy), "div_busy_stall");
      apply(v(1, 0, 0, 0, 0, 14, 1, 0, 1, 0, 0, 0, Z), "div_mflo_issue");

      apply(v(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, Z), "mult_start");
      for (int i = 0; i < 5; i++)
         apply(v(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, e(0,0,0,0,2'd0,2'd0,1)), "mult_busy");
      apply(v(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, Z), "mult_done");

      // reset while a load-use and an MDU stall are both pending
      apply(v(1, 1, 0, 1, 0, 15, 1, 1, 0, 1, 1, 0, Z), "rst_seq_lw_div");
      t = v(1, 15, 0, 1, 0, 0, 0, 0, 1, 0, 0, 0, stall_busy);
      t.rst = 1'b1;
      apply(t, "rst_during_stall");
      apply(v(1, 15, 0, 1, 0, 0, 0, 0, 1, 0, 0, 0, Z), "rst_cleared");
`ifdef HAZARD_PERF_EN
      checks++;
      if (perf_stall_cnt !== 32'd0 || perf_flush_cnt !== 32'd0) begin
         errors++;
         $display("FAIL perf_after_reset: got stall=%0d flush=%0d want 0 0",
                  perf_stall_cnt, perf_flush_cnt);
      end
`endif

      // idle D with random fields must never raise a hazard
      for (int i = 0; i < 8; i++) begin
         t = v(0, 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)),
               1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
               5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)),
               1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 0, 0, 0, Z);
         apply(t, "idle_random");
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Pipeline hazard controller for the 5-stage core (F/D/E/M/W).
- Keeps a registered scoreboard of in-flight destinations for E, M and W.
- Drives the fetch/decode stall, decode/execute flush, the E-stage forwarding selects ahead of the ALU operand muxes, and a multi-cycle mult/div busy counter.
- Sits beside the decode stage; all outputs go to pipeline-register enables/clears and operand muxes.

Parameters:
- MULT_CYCLES, 5, busy cycles after a mult/multu issues in E (range 1-15).
- DIV_CYCLES, 10, busy cycles after a div/divu issues in E (range 1-15).

Ports:
- clk  in  1  core clock.
- reset  in  1  synchronous, active-high reset.
- id_valid  in  1  D stage holds a real instruction.
- id_rs  in  5  D-stage rs field.
- id_rt  in  5  D-stage rt field.
- id_use_rs  in  1  D instruction reads rs.
- id_use_rt  in  1  D instruction reads rt (includes store data).
- id_write_addr  in  5  D-stage destination: rd, rt or 31 after reg-dst/jal selection.
- id_reg_write  in  1  D instruction writes the register file.
- id_is_load  in  1  D instruction is a load.
- id_is_mdu  in  1  D instruction is mult/div/mfhi/mflo/mthi/mtlo.
- ex_mdu_start  in  1  mult/div in E this cycle.
- ex_mdu_is_div  in  1  qualifies ex_mdu_start: 1 = div, 0 = mult.
- ex_branch_taken  in  1  branch/jump resolved taken in E.
- stall_f  out  1  hold PC.
- stall_d  out  1  hold the F/D register.
- flush_d  out  1  clear the F/D register.
- flush_e  out  1  load a bubble into the D/E register.
- fwd_a_sel  out  2  E-stage src A: 0 = RF, 1 = M-stage mem_data (alu_out or pc+8), 2 = W-stage write_data.
- fwd_b_sel  out  2  E-stage src B/store data, same encoding.
- mdu_busy  out  1  mult/div unit occupied.

Behaviour:
- Scoreboard: three registered entries, E, M and W, each {valid, addr[4:0], is_load}.
  - Each cycle W<=M and M<=E.
  - E<=D info when no stall/flush; otherwise E<=invalid.
  - Entry valid only if reg_write is set and addr!=0.
- Match rule: src matches an entry if the entry is valid, the entry addr equals src, src!=0 and the corresponding use bit is set.
- Load-use stall (combinational):
  - lu = id_valid and any D source matches the E entry with is_load=1.
  - Effect: stall_f=stall_d=1, flush_e=1, exactly one cycle per dependency.
- MDU stall: ms = id_valid & id_is_mdu & (mdu_busy | ex_mdu_start). Same effect as lu, held for as long as the condition holds.
- Forwarding selects:
  - Computed in D, registered into fwd_*_sel on the cycle D advances to E; valid during that instruction's E cycle.
  - Priority: E-entry match (non-load) gives 1; else M-entry match gives 2; else 0.
  - The register file is write-before-read, so W needs no bypass.
  - On a stall/flush, the registered selects go to 0 with the bubble.
- Branch: ex_branch_taken gives flush_d=1 and flush_e=1 in the same cycle.
  - Branch overrides lu/ms: stall_f=stall_d=0 that cycle.
  - The flushed E entry becomes invalid on the next edge.
- MDU counter (4 bits):
  - Loads MULT_CYCLES or DIV_CYCLES on ex_mdu_start, then decrements to 0.
  - mdu_busy = (cnt != 0), registered.
  - A new start while busy reloads the counter (cannot occur legally; no error).
- Reset: scoreboard invalid, cnt=0, fwd_*_sel=0, mdu_busy=0.
  - Combinational outputs are 0 whenever id_valid=0 and there is no branch.
  - Reset mid-stall clears everything the next cycle.

Optional Feature:
- Macro HAZARD_PERF_EN.
- Defined:
  - Adds outputs perf_stall_cnt[31:0] (cycles with stall_d=1) and perf_flush_cnt[31:0] (cycles with ex_branch_taken=1).
  - Both counters reset to 0 and wrap at 2^32.
- Undefined: ports and logic absent; behaviour otherwise identical.

Decomposition:
- Shared package: FWD_RF=2'd0, FWD_MEM=2'd1, FWD_WB=2'd2; the scoreboard entry struct typedef; MULT/DIV default cycle constants.
- One natural sub-module, mdu_busy_cnt: counter, load and busy flag.

Test Plan:
- Back-to-back ALU dependency: add $3 then sub $4,$3,$5 -> no stall; sub in E with fwd_a_sel=1. Next instr using $3 one slot later -> fwd_*_sel=2.
- Load-use: lw $8 then add $9,$8,$8 -> stall_f=stall_d=flush_e=1 for exactly 1 cycle; add then enters E with fwd_a_sel=fwd_b_sel=2.
- Register 0: add $0 then use $0 -> no stall, fwd_*_sel=0.
- Div then mflo: ex_mdu_start with is_div=1 -> mdu_busy for 10 cycles; mflo in D stalls 11 cycles total (start cycle + 10) and issues on the cycle mdu_busy falls.
- Taken branch coinciding with a load-use stall -> flush_d=flush_e=1, stall_f=0; the next cycle shows no residual stall.
- Assert reset during an MDU stall -> next cycle mdu_busy=0, all outputs 0. With HAZARD_PERF_EN defined, the counters read 0.
